anneal_sequencer: RTL

- FSM that sequences the replica node array through a full annealing run.
- Each iteration: random/opt pulse, distance-delta accumulation, Metropolis accept, then an optional replica exchange, repeated for a programmed iteration count.
- Drives the array top-level command inputs: random_run, run_distance, opt_com, c_metropolis, run_command, c_exchange, exchange_valid.
- Sits between the host/CSR interface and the replica array; shares the array with no other requester.

---
 rtl/anneal_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/anneal_sequencer.sv
// Annealing run sequencer: steps the replica node array through random/opt, distance,
// Metropolis and optional exchange phases for a programmed number of iterations.

package anneal_pkg;
   typedef enum logic [1:0] {
      OPT_THR = 2'd0,
      OPT_OR1 = 2'd1,
      OPT_TWO = 2'd2
   } opt_command_t;

   typedef enum logic [1:0] {
      EX_NOP  = 2'd0,
      EX_SELF = 2'd1,
      EX_PREV = 2'd2,
      EX_FOLW = 2'd3
   } exchange_command_t;
endpackage

module anneal_sequencer
   import anneal_pkg::*;
#(
   parameter int DIST_WAIT = 21,
   parameter int MET_WAIT  = 4,
   parameter int OPT_WAIT  = 6,
   parameter int ITER_W    = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ITER_W-1:0] iter_num,
   input  logic [1:0]        opt_mode,
   input  logic [7:0]        exch_interval,
   input  logic              exch_list,
   output logic              random_run,
   output logic              run_distance,
   output opt_command_t      opt_com,
   output exchange_command_t c_metropolis,
   output logic              run_command,
   output exchange_command_t c_exchange,
   output logic              exchange_valid,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] iter_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_RAND, S_DIST, S_METRO, S_MWAIT, S_EXCH, S_EWAIT, S_EVAL, S_DONE
   } state_t;

   state_t            state, state_next;
   logic [7:0]        wait_cnt;
   logic [ITER_W-1:0] iter_num_q;
   logic [7:0]        exch_int_q;
   logic [7:0]        exch_cnt;
   logic              exch_parity;
   opt_command_t      cur_opt;
   exchange_command_t exch_cmd;

   logic              wait_done;
   logic              exch_due;
   logic              end_iter;
   logic              abort_now;
   logic [ITER_W-1:0] iter_inc;

   // Mode 3 behaves like mode 0: OR1 on even iterations, TWO on odd.
   function automatic opt_command_t opt_pick(input logic [1:0] mode, input logic odd);
      case (mode)
         2'd1:    return OPT_OR1;
         2'd2:    return OPT_TWO;
         default: return odd ? OPT_TWO : OPT_OR1;
      endcase
   endfunction

   assign wait_done = (wait_cnt == 8'd0);
   assign exch_due  = (exch_int_q != 8'd0) && (exch_cnt == exch_int_q - 8'd1);
   assign iter_inc  = iter_count + ITER_W'(1);
   assign end_iter  = (state == S_MWAIT && wait_done && !exch_due) || (state == S_EVAL);
   assign abort_now = abort && (state != S_IDLE) && (state != S_DONE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   // NOTE: defaulting state_next first keeps this block free of inferred latches.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = (iter_num == '0) ? S_DONE : S_RAND;
         S_RAND:  state_next = S_DIST;
         S_DIST:  if (wait_done) state_next = S_METRO;
         S_METRO: state_next = S_MWAIT;
         S_MWAIT: if (wait_done) begin
                     if (exch_due)                  state_next = S_EXCH;
                     else if (iter_inc == iter_num_q) state_next = S_DONE;
                     else                           state_next = S_RAND;
                  end
         S_EXCH:  state_next = S_EWAIT;
         S_EWAIT: if (wait_done) state_next = S_EVAL;
         S_EVAL:  state_next = (iter_inc == iter_num_q) ? S_DONE : S_RAND;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (abort_now) state_next = S_IDLE;
   end

   always_comb begin
      random_run     = (state == S_RAND);
      run_distance   = (state == S_DIST) && (wait_cnt == 8'(DIST_WAIT - 1));
      opt_com        = (state == S_RAND || state == S_DIST) ? cur_opt : OPT_THR;
      c_metropolis   = (state == S_METRO) ? EX_SELF : EX_NOP;
      run_command    = (state == S_EXCH);
      c_exchange     = (state == S_EXCH) ? exch_cmd : EX_NOP;
      exchange_valid = (state == S_EVAL);
      busy           = (state != S_IDLE) && (state != S_DONE);
      done           = (state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt    <= 8'd0;
         iter_count  <= '0;
         iter_num_q  <= '0;
         exch_int_q  <= 8'd0;
         exch_cnt    <= 8'd0;
         exch_parity <= 1'b0;
         cur_opt     <= OPT_THR;
         exch_cmd    <= EX_NOP;
      end else begin
         if (state_next == S_DIST && state != S_DIST)
            wait_cnt <= 8'(DIST_WAIT - 1);
         else if (state_next == S_MWAIT && state != S_MWAIT)
            wait_cnt <= 8'(MET_WAIT - 1);
         else if (state_next == S_EWAIT && state != S_EWAIT)
            wait_cnt <= 8'(OPT_WAIT - 1);
         else if (!wait_done)
            wait_cnt <= wait_cnt - 8'd1;

         if (state == S_IDLE && start) begin
            iter_num_q  <= iter_num;
            exch_int_q  <= exch_interval;
            iter_count  <= '0;
            exch_cnt    <= 8'd0;
            exch_parity <= 1'b0;
            cur_opt     <= opt_pick(opt_mode, 1'b0);
         end

         // An aborted iteration leaves the counters at their completed values.
         if (!abort_now) begin
            if (end_iter) begin
               iter_count <= iter_inc;
               cur_opt    <= opt_pick(opt_mode, iter_inc[0]);
            end
            if (state == S_MWAIT && wait_done && !exch_due && exch_int_q != 8'd0)
               exch_cnt <= exch_cnt + 8'd1;
            if (state == S_MWAIT && wait_done && exch_due)
               exch_cmd <= exch_list ? EX_NOP : (exch_parity ? EX_FOLW : EX_PREV);
            if (state == S_EXCH) begin
               exch_parity <= ~exch_parity;
               exch_cnt    <= 8'd0;
            end
         end
      end
   end

endmodule
